seq_div: RTL and testbench



---
 rtl/arith_pkg.sv | 15 +
 rtl/div_step.sv | 29 ++
 rtl/seq_div.sv | 132 +++++++++++++
 tb/tb_seq_div.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: FSM state encoding and default operand
// widths used by both the multiplier and the divider.
package arith_pkg;

  localparam int WA_DEF = 8;  // dividend / quotient / product width
  localparam int WB_DEF = 4;  // divisor / remainder / multiplier width

  // Encoding 2'b11 is unused; the divider FSM falls back to IDLE from it.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits. Purely combinational.
module div_step #(
  parameter int WB = 4
) (
  input  logic [WB-1:0] p,      // partial remainder, always < dv
  input  logic          x_msb,  // next dividend bit to bring down
  input  logic [WB-1:0] dv,     // divisor (non-zero when used)
  output logic [WB-1:0] p_nxt,  // partial remainder after this step
  output logic          q_bit   // quotient bit produced by this step
);

  logic [WB:0] s;
  logic [WB:0] diff;

  // Trial subtraction in WB+1 bits; p < dv guarantees the result fits in WB.
  always_comb begin
    s    = {p, x_msb};
    diff = s - {1'b0, dv};
    if (s >= {1'b0, dv}) begin
      q_bit = 1'b1;
      p_nxt = diff[WB-1:0];
    end else begin
      q_bit = 1'b0;
      p_nxt = s[WB-1:0];
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider: WA-bit dividend by WB-bit divisor,
// one quotient bit per clock, start/ack handshake, divide-by-zero flag.
// WB must be smaller than WA.
module seq_div
  import arith_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WB = WB_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic [WA-1:0] N,
  input  logic [WB-1:0] D,
  output logic [WA-1:0] Q,
  output logic [WB-1:0] Rem,
  output logic          ack,
  output logic          err,
  output logic          busy
);

  localparam int CW = $clog2(WA + 1);

  state_e        state_q, state_d;
  logic [WA-1:0] x_q, x_d;      // dividend shifting out, quotient shifting in
  logic [WB-1:0] dv_q, dv_d;    // latched divisor
  logic [WB-1:0] p_q, p_d;      // partial remainder
  logic [CW-1:0] cnt_q, cnt_d;  // steps left
  logic [WA-1:0] q_q, q_d;
  logic [WB-1:0] rem_q, rem_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic [WB-1:0] p_step;
  logic          q_bit;

  div_step #(.WB(WB)) u_step (
    .p     (p_q),
    .x_msb (x_q[WA-1]),
    .dv    (dv_q),
    .p_nxt (p_step),
    .q_bit (q_bit)
  );

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    dv_d    = dv_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    ack_d   = ack_q;
    err_d   = err_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = N;
          dv_d    = D;
          p_d     = '0;
          cnt_d   = CW'(WA);
          ack_d   = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (dv_q == '0) begin
          // Divide by zero resolves on the first RUN edge.
          q_d     = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          p_d   = p_step;
          x_d   = {x_q[WA-2:0], q_bit};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // Last step: publish the post-step quotient and remainder.
            q_d     = {x_q[WA-2:0], q_bit};
            rem_d   = p_step;
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      dv_q    <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      dv_q    <= dv_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign Q    = q_q;
  assign Rem  = rem_q;
  assign ack  = ack_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed + exhaustive bench for seq_div with an expected-result queue.
module tb_seq_div;

  localparam int WA = 8;
  localparam int WB = 4;

  typedef struct {
    logic [WA-1:0] q;
    logic [WB-1:0] rem;
    logic          err;
  } exp_t;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic [WA-1:0] N;
  logic [WB-1:0] D;
  logic [WA-1:0] Q;
  logic [WB-1:0] Rem;
  logic          ack, err, busy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  seq_div #(.WA(WA), .WB(WB)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .N(N), .D(D),
    .Q(Q), .Rem(Rem), .ack(ack), .err(err), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference product by repeated addition, standing in for the multiplier.
  function automatic int mul_ref(input int a, input int b);
    int acc = 0;
    for (int i = 0; i < b; i++) acc += a;
    return acc;
  endfunction

  // Drive a request and push its expected result; returns 1ns after capture.
  task automatic go(input int n, input int d);
    exp_t e;
    @(negedge Clk);
    N = WA'(n); D = WB'(d); start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    if (d == 0) begin e.q = '0; e.rem = '0; e.err = 1'b1; end
    else begin e.q = WA'(n / d); e.rem = WB'(n % d); e.err = 1'b0; end
    sb.push_back(e);
  endtask

  // Wait for ack (bounded), check latency and result, then step past DONE.
  task automatic wait_ack(input string tag, input int lat);
    int   n = 0;
    exp_t e;
    do begin @(posedge Clk); #1; n++; end while (!ack && n < 40);
    chk({tag, ".lat"}, n, lat);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".Q"},   32'(Q),   32'(e.q));
      chk({tag, ".Rem"}, 32'(Rem), 32'(e.rem));
      chk({tag, ".err"}, 32'(err), 32'(e.err));
      chk({tag, ".busy"}, 32'(busy), 0);
    end
    @(posedge Clk); #1;  // DONE -> IDLE
  endtask

  initial begin
    int acks;
    Rst = 1'b1; start = 1'b0; N = '0; D = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.Q", 32'(Q), 0);
    chk("rst.Rem", 32'(Rem), 0);
    chk("rst.ack", 32'(ack), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.busy", 32'(busy), 0);
    @(negedge Clk); Rst = 1'b0;

    // Basic operation and handshake.
    go(35, 7);
    chk("c1.busy", 32'(busy), 1);
    chk("c1.ack", 32'(ack), 0);
    wait_ack("c1", 8);
    chk("c1.idle_busy", 32'(busy), 0);
    chk("c1.ack_hold", 32'(ack), 1);
    chk("c1.Q_hold", 32'(Q), 5);

    go(200, 3);  wait_ack("c2", 8);
    go(225, 15); wait_ack("c3", 8);
    go(7, 9);    wait_ack("c4", 8);

    // Divide by zero resolves one edge after capture; next capture clears err.
    go(100, 0);  wait_ack("dz", 1);
    chk("dz.err_hold", 32'(err), 1);
    go(9, 2);
    chk("dz.err_clr", 32'(err), 0);
    chk("dz.ack_clr", 32'(ack), 0);
    wait_ack("dz_next", 8);

    // start pulsed at C+3 is ignored.
    go(123, 11);
    repeat (2) @(posedge Clk);
    @(negedge Clk); N = 8'd1; D = 4'd1; start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    wait_ack("ign", 5);
    repeat (2) @(posedge Clk);
    #1;
    chk("ign.no_restart", 32'(busy), 0);

    // Reset at C+4 aborts the operation; no ack follows.
    go(150, 7);
    repeat (3) @(posedge Clk);
    @(negedge Clk); Rst = 1'b1;
    @(posedge Clk); #1;
    chk("ra.busy", 32'(busy), 0);
    chk("ra.ack", 32'(ack), 0);
    chk("ra.Q", 32'(Q), 0);
    chk("ra.Rem", 32'(Rem), 0);
    chk("ra.err", 32'(err), 0);
    void'(sb.pop_back());
    Rst = 1'b0;
    acks = 0;
    repeat (10) begin @(posedge Clk); #1; if (ack) acks++; end
    chk("ra.no_ack", acks, 0);
    go(150, 7); wait_ack("ra_next", 8);

    // start held high: restart in the first IDLE cycle clears ack.
    @(negedge Clk); N = 8'd50; D = 4'd5; start = 1'b1;
    @(posedge Clk); #1;
    sb.push_back('{q: 8'd10, rem: 4'd0, err: 1'b0});
    wait_ack("hold1", 8);
    sb.push_back('{q: 8'd10, rem: 4'd0, err: 1'b0});
    @(posedge Clk); #1;
    chk("hold.ack_clr", 32'(ack), 0);
    chk("hold.busy", 32'(busy), 1);
    start = 1'b0;
    wait_ack("hold2", 8);

    // Chain with the multiplier: N = A*B, D = B -> Q = A, Rem = 0.
    begin
      int a_tab[5] = '{17, 255, 85, 0, 31};
      int b_tab[5] = '{15, 1, 3, 7, 8};
      for (int i = 0; i < 5; i++) begin
        go(mul_ref(a_tab[i], b_tab[i]), b_tab[i]);
        wait_ack("mul", 8);
        chk("mul.Q_is_A", 32'(Q), 32'(a_tab[i]));
      end
    end

    // Exhaustive sweep over non-zero divisors.
    for (int n = 0; n < 256; n++) begin
      for (int d = 1; d < 16; d++) begin
        go(n, d);
        wait_ack("sw", 8);
        chk("sw.ident", 32'(int'(Q) * d + int'(Rem)), 32'(n));
        chk("sw.rem_lt_d", 32'(int'(Rem) < d), 1);
      end
    end

    chk("sb.drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
